// File: rtl/adder_pkg.sv
// Shared types and defaults for the bit-serial adder block.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } serial_add_state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Start/busy/done handshake plus operand and result buses of the serial adder.
interface serial_adder_ctrl_if
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (
    output start, a, b,
    input  busy, done, sum, carry_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, carry_out
  );

endinterface

// File: rtl/serial_adder_ctrl_fa.sv
// Full-adder cell built from two behavioral half adders and an OR on the carries.
module half_adder_behavioral (
  input  logic i_a,
  input  logic i_b,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_a ^ i_b;
  assign o_carry = i_a & i_b;

endmodule

module full_adder_hb (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder_behavioral u_ha0 (
    .i_a     (i_a),
    .i_b     (i_b),
    .o_sum   (w_s0),
    .o_carry (w_c0)
  );

  half_adder_behavioral u_ha1 (
    .i_a     (w_s0),
    .i_b     (i_cin),
    .o_sum   (o_sum),
    .o_carry (w_c1)
  );

  // The two half-adder carries can never both be high, so OR is exact.
  assign o_cout = w_c0 | w_c1;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial unsigned adder: one bit per clock, LSB first, start/busy/done handshake.
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                clk,
  input logic                rst_n,
  serial_adder_ctrl_if.slave bus
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  serial_add_state_t r_state;
  serial_add_state_t w_next_state;

  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry_out;

  logic             w_cell_sum;
  logic             w_cell_carry;
  logic             w_load;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_next;

  full_adder_hb u_fa (
    .i_a    (r_ra[0]),
    .i_b    (r_rb[0]),
    .i_cin  (r_carry),
    .o_sum  (w_cell_sum),
    .o_cout (w_cell_carry)
  );

  // start is only honoured outside SHIFT; during SHIFT it is simply ignored.
  assign w_load     = bus.start && (r_state != SHIFT);
  assign w_last     = (r_state == SHIFT) && (r_bit_cnt == LAST);
  assign w_acc_next = (r_acc >> 1) | {w_cell_sum, {(WIDTH-1){1'b0}}};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: default assigned first so no path through the case infers a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_next_state = SHIFT;
      SHIFT:   if (w_last)    w_next_state = DONE;
      DONE:    w_next_state = bus.start ? SHIFT : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ra        <= '0;
      r_rb        <= '0;
      r_acc       <= '0;
      r_bit_cnt   <= '0;
      r_carry     <= 1'b0;
      r_sum       <= '0;
      r_carry_out <= 1'b0;
    end else if (w_load) begin
      r_ra      <= bus.a;
      r_rb      <= bus.b;
      r_acc     <= '0;
      r_bit_cnt <= '0;
      r_carry   <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_ra      <= r_ra >> 1;
      r_rb      <= r_rb >> 1;
      r_acc     <= w_acc_next;
      r_carry   <= w_cell_carry;
      r_bit_cnt <= r_bit_cnt + CW'(1);
      // Result registers only move on the final bit, so they hold through SHIFT.
      if (w_last) begin
        r_sum       <= w_acc_next;
        r_carry_out <= w_cell_carry;
      end
    end
  end

  assign bus.busy      = (r_state == SHIFT);
  assign bus.done      = (r_state == DONE);
  assign bus.sum       = r_sum;
  assign bus.carry_out = r_carry_out;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed-vector bench for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;
  import adder_pkg::*;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.sum !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h expected 00", bus.sum); end
    checks++; if (bus.carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b expected 0", bus.carry_out); end
  endtask

  // Start one addition, measure the cycle at which done appears and check results.
  task automatic run_op(input logic [7:0] a_v, input logic [7:0] b_v,
                        input logic [7:0] exp_sum, input logic exp_co, input string name);
    logic [7:0] prev_sum;
    logic       prev_co;
    int         lat;
    bit         busy_ok;
    bit         hold_ok;
    prev_sum  = bus.sum;
    prev_co   = bus.carry_out;
    bus.start = 1'b1;
    bus.a     = a_v;
    bus.b     = b_v;
    tick();
    bus.start = 1'b0;
    bus.a     = ~a_v;
    bus.b     = ~b_v;
    lat       = 1;
    busy_ok   = 1'b1;
    hold_ok   = 1'b1;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.sum !== prev_sum || bus.carry_out !== prev_co) hold_ok = 1'b0;
      tick();
      lat++;
    end
    checks++; if (lat != 9) begin errors++; $display("FAIL %s_latency: got %0d expected 9", name, lat); end
    checks++; if (!busy_ok) begin errors++; $display("FAIL %s_busy_shift: got low expected high", name); end
    checks++; if (!hold_ok) begin errors++; $display("FAIL %s_hold: result changed during SHIFT expected %h", name, prev_sum); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s_busy_done: got %b expected 0", name, bus.busy); end
    checks++; if (bus.sum !== exp_sum) begin errors++; $display("FAIL %s_sum: got %h expected %h", name, bus.sum, exp_sum); end
    checks++; if (bus.carry_out !== exp_co) begin errors++; $display("FAIL %s_carry: got %b expected %b", name, bus.carry_out, exp_co); end
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse: got %b expected 0", name, bus.done); end
    checks++; if (bus.sum !== exp_sum) begin errors++; $display("FAIL %s_sum_hold: got %h expected %h", name, bus.sum, exp_sum); end
  endtask

  task automatic test_add_vectors();
    run_op(8'hA5, 8'h5A, 8'hFF, 1'b0, "a5_5a");
    run_op(8'hFF, 8'h01, 8'h00, 1'b1, "ff_01");
    run_op(8'hFF, 8'hFF, 8'hFE, 1'b1, "ff_ff");
  endtask

  task automatic test_ignored_start();
    int n_done;
    int first_c;
    logic [7:0] got_sum;
    logic       got_co;
    n_done    = 0;
    first_c   = -1;
    got_sum   = 'x;
    got_co    = 1'bx;
    bus.start = 1'b1;
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    for (int c = 1; c <= 30; c++) begin
      tick();
      bus.start = (c == 3);
      if (c == 3) begin
        bus.a = 8'hFF;
        bus.b = 8'hFF;
      end
      if (bus.done === 1'b1) begin
        n_done++;
        if (first_c < 0) begin
          first_c = c;
          got_sum = bus.sum;
          got_co  = bus.carry_out;
        end
      end
    end
    bus.start = 1'b0;
    checks++; if (n_done != 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", n_done); end
    checks++; if (first_c != 9) begin errors++; $display("FAIL ignore_latency: got %0d expected 9", first_c); end
    checks++; if (got_sum !== 8'h46) begin errors++; $display("FAIL ignore_sum: got %h expected 46", got_sum); end
    checks++; if (got_co !== 1'b0) begin errors++; $display("FAIL ignore_carry: got %b expected 0", got_co); end
  endtask

  task automatic test_reset_mid_op();
    int n_done;
    bus.start = 1'b1;
    bus.a     = 8'h80;
    bus.b     = 8'h80;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
    checks++; if (bus.sum !== 8'h00) begin errors++; $display("FAIL midrst_sum: got %h expected 00", bus.sum); end
    checks++; if (bus.carry_out !== 1'b0) begin errors++; $display("FAIL midrst_carry: got %b expected 0", bus.carry_out); end
    rst_n  = 1'b1;
    n_done = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) n_done++;
    end
    checks++; if (n_done != 0) begin errors++; $display("FAIL midrst_activity: got %0d active cycles expected 0", n_done); end
    run_op(8'h01, 8'h02, 8'h03, 1'b0, "fresh_01_02");
  endtask

  task automatic test_back_to_back();
    int n_done;
    n_done    = 0;
    bus.start = 1'b1;
    bus.a     = 8'h0F;
    bus.b     = 8'h01;
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (c == 1) begin
        bus.a = 8'hF0;
        bus.b = 8'h10;
      end
      if (bus.done === 1'b1) begin
        n_done++;
        if (n_done == 1) begin
          checks++; if (c != 9) begin errors++; $display("FAIL b2b_first_cycle: got %0d expected 9", c); end
          checks++; if (bus.sum !== 8'h10 || bus.carry_out !== 1'b0) begin
            errors++; $display("FAIL b2b_first_result: got %h/%b expected 10/0", bus.sum, bus.carry_out);
          end
        end else if (n_done == 2) begin
          checks++; if (c != 18) begin errors++; $display("FAIL b2b_second_cycle: got %0d expected 18", c); end
          checks++; if (bus.sum !== 8'h00 || bus.carry_out !== 1'b1) begin
            errors++; $display("FAIL b2b_second_result: got %h/%b expected 00/1", bus.sum, bus.carry_out);
          end
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    checks++; if (n_done != 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", n_done); end
  endtask

  initial begin
    test_reset();
    test_add_vectors();
    test_ignored_start();
    test_reset_mid_op();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
